// File: rtl/regfile_scoreboard.sv
// Integer register file with a post-reset clear sweep, pending-write scoreboard and debug tap.
// Optional same-cycle write-to-read forwarding when RF_BYPASS_EN is defined.
module regfile_scoreboard #(
   parameter int XLEN    = 32,
   parameter int NREGS   = 32,
   parameter int AW      = $clog2(NREGS),
   parameter int DBG_REG = 10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   A1_D,
   input  logic [AW-1:0]   A2_D,
   output logic [XLEN-1:0] RD1_D,
   output logic [XLEN-1:0] RD2_D,
   input  logic            Issue_D,
   input  logic [AW-1:0]   Rd_D,
   output logic            Busy1_D,
   output logic            Busy2_D,
   input  logic [AW-1:0]   A3_W,
   input  logic [XLEN-1:0] WD3_W,
   input  logic            WE3_W,
   output logic            rf_ready,
   output logic [XLEN-1:0] dbg_reg
);

   // state    | meaning
   // ST_CLEAR | sweeping zeros into every register, file closed to traffic
   // ST_RUN   | normal operation, leaves only on rst
   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

   state_t            state_q, state_d;
   logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
   logic [NREGS-1:0]  pending_q, pending_d;
   logic [XLEN-1:0]   regs_q [1:NREGS-1];
   logic [XLEN-1:0]   regs_d [1:NREGS-1];

   logic a1_ok, a2_ok, a3_ok, rd_ok;
   logic a1_nz, a2_nz, we_ok, run;

   // Address range checks only exist when NREGS leaves unused codes in AW bits.
   generate
      if (NREGS == (1 << AW)) begin : g_full_range
         assign a1_ok = 1'b1;
         assign a2_ok = 1'b1;
         assign a3_ok = 1'b1;
         assign rd_ok = 1'b1;
      end else begin : g_part_range
         localparam logic [AW-1:0] LIMIT = AW'(NREGS);
         assign a1_ok = (A1_D < LIMIT);
         assign a2_ok = (A2_D < LIMIT);
         assign a3_ok = (A3_W < LIMIT);
         assign rd_ok = (Rd_D < LIMIT);
      end
   endgenerate

   assign run   = (state_q == ST_RUN);
   assign a1_nz = a1_ok && (A1_D != '0);
   assign a2_nz = a2_ok && (A2_D != '0);
   assign we_ok = run && WE3_W && a3_ok && (A3_W != '0);

   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      unique case (state_q)
         ST_CLEAR: begin
            clr_ptr_d = clr_ptr_q + AW'(1);
            if (clr_ptr_q == LAST_IDX) begin
               state_d   = ST_RUN;
               clr_ptr_d = '0;
            end
         end
         ST_RUN: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_CLEAR;
         end
      endcase
   end

   // Clear before set so a new producer issued in the writeback cycle stays pending.
   always_comb begin
      pending_d = pending_q;
      if (run) begin
         if (WE3_W && a3_ok) begin
            pending_d[A3_W] = 1'b0;
         end
         if (Issue_D && rd_ok && (Rd_D != '0)) begin
            pending_d[Rd_D] = 1'b1;
         end
      end
   end

   always_comb begin
      regs_d = regs_q;
      for (int i = 1; i < NREGS; i++) begin
         if (state_q == ST_CLEAR) begin
            if (clr_ptr_q == AW'(i)) begin
               regs_d[i] = '0;
            end
         end else if (we_ok && (A3_W == AW'(i))) begin
            regs_d[i] = WD3_W;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_CLEAR;
         clr_ptr_q <= '0;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
         pending_q <= pending_d;
      end
   end

   // Storage is not reset; the sweep zeroes it once rst is released.
   always_ff @(posedge clk) begin
      if (!rst) begin
         regs_q <= regs_d;
      end
   end

   always_comb begin
      RD1_D   = '0;
      RD2_D   = '0;
      Busy1_D = 1'b0;
      Busy2_D = 1'b0;
      if (run) begin
         if (a1_nz) begin
            RD1_D   = regs_q[A1_D];
            Busy1_D = pending_q[A1_D];
         end
         if (a2_nz) begin
            RD2_D   = regs_q[A2_D];
            Busy2_D = pending_q[A2_D];
         end
`ifdef RF_BYPASS_EN
         if (we_ok && (A3_W == A1_D)) begin
            RD1_D   = WD3_W;
            Busy1_D = 1'b0;
         end
         if (we_ok && (A3_W == A2_D)) begin
            RD2_D   = WD3_W;
            Busy2_D = 1'b0;
         end
`endif
      end
   end

   assign rf_ready = run;

   generate
      if ((DBG_REG >= 1) && (DBG_REG < NREGS)) begin : g_dbg
         assign dbg_reg = run ? regs_q[DBG_REG] : '0;
      end else begin : g_dbg_none
         assign dbg_reg = '0;
      end
   endgenerate

endmodule
